bip_host_link: RTL

//  Initiator end of the BIP UART command/result link. On req, sends one command byte through
//  the UART TX, then collects the 3-byte result frame (ACC[7:0], ACC[15:8], clock count) from UART RX.

---
 rtl/bip_host_link_pkg.sv | 16 +
 rtl/bip_host_link_tick_edge_det.sv | 21 ++
 rtl/bip_host_link.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bip_host_link_pkg.sv
// Shared definitions for the BIP host link: FSM state encoding and the default command byte.
package bip_host_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        WAIT_ACC1 = 3'd2,
        WAIT_ACC2 = 3'd3,
        WAIT_CLK  = 3'd4,
        DONE      = 3'd5
    } link_state_t;

    // Bit0 set tells the CPU side to start; the CPU-side UART interface uses the same value.
    localparam logic [7:0] DEF_CMD_BYTE = 8'h01;

endpackage

// File: rtl/bip_host_link_tick_edge_det.sv
// Registers a UART done tick and flags its rising edge, so a held level counts as one event.
module bip_host_link_tick_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_tick;
        end
    end

    assign o_edge = i_tick & ~r_prev;

endmodule

// File: rtl/bip_host_link.sv
// bip_host_link: BIP UART initiator - sends one command byte, then collects the 3-byte result frame.
// Define BIP_LINK_TIMEOUT_EN to add a per-byte wait limit that aborts with a timeout_err pulse.
module bip_host_link
    import bip_host_link_pkg::*;
#(
    parameter int                       NBIT_DATA_LEN  = 8,
    parameter int                       len_data       = 16,
    parameter logic [NBIT_DATA_LEN-1:0] CMD_BYTE       = NBIT_DATA_LEN'(DEF_CMD_BYTE)
`ifdef BIP_LINK_TIMEOUT_EN
    ,
    parameter int                       TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     tx_done_tick,
    input  logic                     rx_done_tick,
    input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
    output logic                     tx_start,
    output logic [NBIT_DATA_LEN-1:0] tx_data_out,
    output logic                     busy,
    output logic                     result_valid,
    output logic [len_data-1:0]      acc_out,
    output logic [NBIT_DATA_LEN-1:0] clk_count_out,
    output logic                     timeout_err
);

    link_state_t              r_state;
    link_state_t              w_next;
    logic [NBIT_DATA_LEN-1:0] r_tx_data;
    logic [NBIT_DATA_LEN-1:0] r_acc_lo;
    logic [NBIT_DATA_LEN-1:0] r_acc_hi;
    logic [len_data-1:0]      r_acc_out;
    logic [NBIT_DATA_LEN-1:0] r_clk_count_out;
    logic                     w_rx_evt;
    logic                     w_tx_evt;

    bip_host_link_tick_edge_det u_rx_edge (
        .clk    (clk),
        .reset  (reset),
        .i_tick (rx_done_tick),
        .o_edge (w_rx_evt)
    );

    bip_host_link_tick_edge_det u_tx_edge (
        .clk    (clk),
        .reset  (reset),
        .i_tick (tx_done_tick),
        .o_edge (w_tx_evt)
    );

`ifdef BIP_LINK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;
    logic             w_waiting;
    logic             w_timeout;

    assign w_waiting = (r_state == SEND_CMD) || (r_state == WAIT_ACC1) ||
                       (r_state == WAIT_ACC2) || (r_state == WAIT_CLK);
`endif

    always_comb begin
        w_next = r_state;
`ifdef BIP_LINK_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE:      if (req)      w_next = SEND_CMD;
            SEND_CMD:  if (w_tx_evt) w_next = WAIT_ACC1;
            WAIT_ACC1: if (w_rx_evt) w_next = WAIT_ACC2;
            WAIT_ACC2: if (w_rx_evt) w_next = WAIT_CLK;
            WAIT_CLK:  if (w_rx_evt) w_next = DONE;
            DONE:                    w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
`ifdef BIP_LINK_TIMEOUT_EN
        // Only a wait that saw no accepted event this cycle can expire.
        if (w_waiting && (w_next == r_state) &&
            (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            w_next    = IDLE;
            w_timeout = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_tx_data       <= '0;
            r_acc_lo        <= '0;
            r_acc_hi        <= '0;
            r_acc_out       <= '0;
            r_clk_count_out <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && req) begin
                r_tx_data <= CMD_BYTE;
            end
            if (w_rx_evt) begin
                case (r_state)
                    WAIT_ACC1: r_acc_lo <= rx_data_in;
                    WAIT_ACC2: r_acc_hi <= rx_data_in;
                    // Published outputs are loaded together so they appear with the DONE pulse.
                    WAIT_CLK: begin
                        r_acc_out       <= {r_acc_hi, r_acc_lo};
                        r_clk_count_out <= rx_data_in;
                    end
                    default: ;
                endcase
            end
`ifdef BIP_LINK_TIMEOUT_EN
            if (w_timeout) begin
                r_acc_lo <= '0;
                r_acc_hi <= '0;
            end
`endif
        end
    end

`ifdef BIP_LINK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign tx_start      = (r_state == SEND_CMD);
    assign busy          = (r_state != IDLE);
    assign result_valid  = (r_state == DONE);
    assign tx_data_out   = r_tx_data;
    assign acc_out       = r_acc_out;
    assign clk_count_out = r_clk_count_out;

endmodule
